// File: rtl/pattern_11010_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_11010_detector_if
//  Description : Serial data / detection bundle for the 1-1-0-1-0 detector.
//                master : the side that drives the serial bit and observes
//                         the detection strobe and the match counter.
//                slave  : the detector itself.
//  Signals     : in          - serial data bit, one per clock
//                detected    - Mealy detection strobe
//                match_count - saturating number of detections since reset
//  Revision    : 1.0 - initial release
// ============================================================================
interface pattern_11010_detector_if #(
  parameter int CNT_W = 8
);
  logic             in;
  logic             detected;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in,
    input  detected,
    input  match_count
  );

  modport slave (
    input  in,
    output detected,
    output match_count
  );
endinterface
`default_nettype wire

// File: rtl/pattern_11010_detector.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_11010_detector
//  Description : Overlapping serial sequence detector for 1-1-0-1-0 (first
//                bit received first). The detection strobe is combinational
//                (Mealy): it is high during the cycle in which the final 0
//                is present on the input, before the edge that samples it.
//                A saturating counter tallies detections since reset.
//  Ports       : clk    - system clock, rising-edge active
//                reset  - synchronous, active-high reset
//                bus    - slave side of pattern_11010_detector_if
//                         (in, detected, match_count)
//  Parameters  : CNT_W  - width of the saturating match counter
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_11010_detector #(
  parameter int CNT_W = 8
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  pattern_11010_detector_if.slave     bus
);

  // Each state's code equals the length of the pattern prefix currently
  // matched by the tail of the received stream.
  typedef enum logic [2:0] {
    S0 = 3'b000,   // nothing matched
    S1 = 3'b001,   // "1"
    S2 = 3'b010,   // "11"
    S3 = 3'b011,   // "110"
    S4 = 3'b100    // "1101"
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic             detected;
  logic [CNT_W-1:0] match_count;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and Mealy output
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = S0;
    detected   = 1'b0;
    case (state)
      S0: state_next = bus.in ? S1 : S0;
      S1: state_next = bus.in ? S2 : S0;
      // A run of ones always leaves "11" as the useful suffix.
      S2: state_next = bus.in ? S2 : S3;
      S3: state_next = bus.in ? S4 : S0;
      S4: begin
        if (bus.in) begin
          // "11011": the trailing "11" is still a valid prefix.
          state_next = S2;
        end else begin
          // "11010": complete match; no suffix of it is a useful prefix.
          state_next = S0;
          detected   = 1'b1;
        end
      end
      // Unused codes recover to idle without flagging a detection.
      default: begin
        state_next = S0;
        detected   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Saturating detection counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      match_count <= '0;
    end else if (detected && (match_count != CNT_MAX)) begin
      match_count <= match_count + CNT_ONE;
    end
  end

  assign bus.detected    = detected;
  assign bus.match_count = match_count;

endmodule
`default_nettype wire

// File: tb/tb_pattern_11010_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_11010_detector
//  Description : Self-checking bench for pattern_11010_detector. Two
//                instances (CNT_W=8 and CNT_W=2) share one serial stream.
//                A history-based model predicts detection, matched-prefix
//                length and counts; directed vectors carry hand-computed
//                expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_11010_detector;

  logic clk;
  logic reset;

  pattern_11010_detector_if #(.CNT_W(8)) bus8 ();
  pattern_11010_detector_if #(.CNT_W(2)) bus2 ();

  pattern_11010_detector #(.CNT_W(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  pattern_11010_detector #(.CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // both instances see the same serial bit
  logic in_bit;
  assign bus8.in = in_bit;
  assign bus2.in = in_bit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // --------------------------------------------------------------------------
  // Behavioural model: keeps the bits received since reset and matches the
  // pattern against them directly.
  // --------------------------------------------------------------------------
  bit pat [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  bit hist [$];
  int m_cnt   = 0;
  bit m_valid = 0;

  // length of the longest tail of hist that equals a proper prefix of pat
  function automatic int model_prefix_len();
    for (int k = 4; k > 0; k--) begin
      if (hist.size() >= k) begin
        bit ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (hist[hist.size() - k + j] != pat[j]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  // the last four received bits plus the current bit spell the full pattern
  function automatic bit model_det(input bit b);
    int n;
    n = hist.size();
    if (n < 4) return 1'b0;
    for (int j = 0; j < 4; j++)
      if (hist[n - 4 + j] != pat[j]) return 1'b0;
    return (b == pat[4]);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      m_cnt   = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (model_det(in_bit)) m_cnt = m_cnt + 1;
      hist.push_back(in_bit);
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  // compare process: every falling edge once the model is anchored by reset
  always @(negedge clk) begin
    if (m_valid) begin
      int e8;
      int e2;
      bit ed;
      int es;
      ed = model_det(in_bit);
      es = model_prefix_len();
      e8 = (m_cnt > 255) ? 255 : m_cnt;
      e2 = (m_cnt > 3) ? 3 : m_cnt;
      checks++;
      if (bus8.detected !== ed) begin
        errors++;
        $display("FAIL model_det8 t=%0t got %0b want %0b", $time, bus8.detected, ed);
      end
      checks++;
      if (bus2.detected !== ed) begin
        errors++;
        $display("FAIL model_det2 t=%0t got %0b want %0b", $time, bus2.detected, ed);
      end
      checks++;
      if (int'(bus8.match_count) != e8 || $isunknown(bus8.match_count)) begin
        errors++;
        $display("FAIL model_cnt8 t=%0t got %0d want %0d", $time, bus8.match_count, e8);
      end
      checks++;
      if (int'(bus2.match_count) != e2 || $isunknown(bus2.match_count)) begin
        errors++;
        $display("FAIL model_cnt2 t=%0t got %0d want %0d", $time, bus2.match_count, e2);
      end
      checks++;
      if (int'(dut8.state) != es || $isunknown(dut8.state)) begin
        errors++;
        $display("FAIL model_state t=%0t got %0d want %0d", $time, dut8.state, es);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus. Each task is entered and left 1 time unit after a
  // rising edge; literal checks sample 3 units after the edge.
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
    end
  endtask

  // apply bit b; exp_det is the strobe while b is present, c8/c2 the counts
  // visible before the edge that samples b
  task automatic drive(input logic b, input int exp_det, input int c8, input int c2);
    in_bit = b;
    #2;
    chk("det", int'(bus8.detected), exp_det);
    chk("cnt8", int'(bus8.match_count), c8);
    chk("cnt2", int'(bus2.match_count), c2);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset  = 1'b1;
    in_bit = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    chk("rst_state", int'(dut8.state), 0);
    chk("rst_det", int'(bus8.detected), 0);
    chk("rst_cnt8", int'(bus8.match_count), 0);
    chk("rst_cnt2", int'(bus2.match_count), 0);
    #(-0);
  endtask

  initial begin
    reset  = 1'b1;
    in_bit = 1'b0;
    @(posedge clk);
    #1;
    pulse_reset();
    // realign to edge+1 after the 2-unit reset checks
    @(posedge clk);
    #1;

    // basic match: 1 1 0 1 0
    drive(1'b1, 0, 0, 0);
    drive(1'b1, 0, 0, 0);
    drive(1'b0, 0, 0, 0);
    drive(1'b1, 0, 0, 0);
    chk("basic_state_s4", int'(dut8.state), 4);
    drive(1'b0, 1, 0, 0);
    chk("basic_state_s0", int'(dut8.state), 0);

    // overlap/partial: 1 1 0 1 1 0 1 0
    drive(1'b1, 0, 1, 1);
    drive(1'b1, 0, 1, 1);
    drive(1'b0, 0, 1, 1);
    drive(1'b1, 0, 1, 1);
    drive(1'b1, 0, 1, 1);
    chk("ovl_state_s2", int'(dut8.state), 2);
    drive(1'b0, 0, 1, 1);
    drive(1'b1, 0, 1, 1);
    drive(1'b0, 1, 1, 1);

    // runs of ones: 1 1 1 1 0 1 0
    drive(1'b1, 0, 2, 2);
    drive(1'b1, 0, 2, 2);
    drive(1'b1, 0, 2, 2);
    chk("run_state_s2", int'(dut8.state), 2);
    drive(1'b1, 0, 2, 2);
    chk("run_state_s2b", int'(dut8.state), 2);
    drive(1'b0, 0, 2, 2);
    drive(1'b1, 0, 2, 2);
    drive(1'b0, 1, 2, 2);

    // reset mid-sequence: 1 1 0 1, reset, then 0
    drive(1'b1, 0, 3, 3);
    drive(1'b1, 0, 3, 3);
    drive(1'b0, 0, 3, 3);
    drive(1'b1, 0, 3, 3);
    pulse_reset();
    @(posedge clk);
    #1;
    drive(1'b0, 0, 0, 0);

    // five back-to-back patterns: CNT_W=2 counter saturates at 3
    for (int p = 0; p < 5; p++) begin
      int c8;
      int c2;
      c8 = p;
      c2 = (p > 3) ? 3 : p;
      drive(1'b1, 0, c8, c2);
      drive(1'b1, 0, c8, c2);
      drive(1'b0, 0, c8, c2);
      drive(1'b1, 0, c8, c2);
      drive(1'b0, 1, c8, c2);
    end
    drive(1'b0, 0, 5, 3);
    drive(1'b0, 0, 5, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // safety net against a stalled run
  initial begin
    #100000;
    $display("FAIL timeout t=%0t got running want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
